key_conditioner: RTL
====================

Name: key_conditioner

Overview:
Sits between the four active-low board pushbuttons and pong_logic, replacing the direct ~keyN_n connections. Per key it provides a two-flop synchronizer, a counter-based debouncer and one-cycle press/release pulses. It also gives frame-aligned snapshots, so the game sees stable inputs for a whole frame and never loses a short tap. Runs in the pixel clock domain, with reset driven by ~pll_locked | reset.

Parameters:
NUM_KEYS, 4, number of independent key channels
DEBOUNCE_CYCLES, 742500, cycles the synchronized input must differ from the debounced state before accepting (10 ms at 74.25 MHz); legal range 2..2^CNT_W-1
CNT_W, 20, debounce counter width
REPEAT_DELAY_FRAMES, 30, frames held before first auto-repeat (KEY_REPEAT_EN only)
REPEAT_RATE_FRAMES, 6, frames between subsequent repeats (KEY_REPEAT_EN only)

Ports:
clk  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse per frame from video_timing
keys_n  in  NUM_KEYS  raw asynchronous pushbuttons, active-low
held  out  NUM_KEYS  debounced level, active-high
press_pulse  out  NUM_KEYS  one-cycle pulse on debounced press
release_pulse  out  NUM_KEYS  one-cycle pulse on debounced release
held_frame  out  NUM_KEYS  held, sampled at frame_start
pressed_frame  out  NUM_KEYS  1 for the frame after any press (or repeat) occurred

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - sync flops = 0 (inverted domain, i.e. released)
  - debounce counters = 0
  - all outputs = 0
  - press latch = 0
  - repeat counters = 0
- Synchronizer: s1 <= ~keys_n; s2 <= s1. No other logic touches keys_n.
- Per-key debounce, evaluated each cycle:
  - s2 == held: counter <= 0.
  - s2 != held and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != held and counter == DEBOUNCE_CYCLES-1: held <= s2; counter <= 0.
- Timing and glitch rules:
  - A bounce back to the held value restarts the count from 0.
  - Latency from keys_n edge (sampled at edge E) to held change: E+1+DEBOUNCE_CYCLES edges.
  - Total latency in cycles: 2 + DEBOUNCE_CYCLES - 1.
- press_pulse / release_pulse: registered; asserted for exactly one cycle, the same cycle held rises/falls. They are never both high for the same key.
- Press latch, per key:
  - Set by press_pulse.
  - On frame_start: pressed_frame <= latch | press_pulse; latch <= 0.
  - Same-cycle press and frame_start: the press goes into pressed_frame, not the next frame.
- held_frame <= held on frame_start cycles, otherwise holds. It uses held's pre-update value in that cycle.
- Outputs change only on clk edges. All keys are independent. Simultaneous events on different keys produce no interaction.
- Reset mid-debounce discards the count: held returns to 0 and no release_pulse is generated.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - Per-key frame counter counts frame_starts while held=1 and clears when held=0.
  - When it reaches REPEAT_DELAY_FRAMES, the next-frame pressed_frame is forced to 1 and the counter reloads to REPEAT_DELAY_FRAMES-REPEAT_RATE_FRAMES.
  - This repeats every REPEAT_RATE_FRAMES frames while held.
- Undefined: no repeat counters are synthesized. pressed_frame reflects only genuine presses. Ports are unchanged.

Test Plan:
All tests use DEBOUNCE_CYCLES=8 and NUM_KEYS=4.
- Reset: assert reset 3 cycles with keys_n=4'b0000. Expect all outputs 0 during reset; held=4'b0000 until 9 cycles after release.
- Clean press: keys_n[0] 1->0 held stable. Expect held[0] rises exactly 9 cycles after sampling edge, press_pulse[0] high 1 cycle, others 0.
- Bounce: keys_n[1] low 5 cycles, high 2, low 20. Expect a single press_pulse[1], with held[1] rising 9 cycles after the final falling edge.
- Tap between frames: press+release key2 fully between frame_starts. Expect pressed_frame[2]=1 for one frame after next frame_start, then 0; held_frame[2]=0 throughout.
- Simultaneous: press_pulse[3] on the same cycle as frame_start. Expect pressed_frame[3]=1 that frame; latch clear afterwards. Mid-debounce reset yields no pulses.
- KEY_REPEAT_EN, DELAY=3, RATE=2: hold key0 for 10 frames. Expect pressed_frame[0] high in frames 1, 4, 6, 8, 10 after press.

Source files
------------

// File: rtl/key_conditioner.sv
// Synchronizes, debounces and frame-aligns the active-low board pushbuttons.
// Define KEY_REPEAT_EN to add per-key auto-repeat on pressed_frame.
module key_conditioner #(
    parameter int unsigned NUM_KEYS            = 4,
    parameter int unsigned DEBOUNCE_CYCLES     = 742500,
    parameter int unsigned CNT_W               = 20,
    parameter int unsigned REPEAT_DELAY_FRAMES = 30,
    parameter int unsigned REPEAT_RATE_FRAMES  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [NUM_KEYS-1:0] keys_n,
    output logic [NUM_KEYS-1:0] held,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] held_frame,
    output logic [NUM_KEYS-1:0] pressed_frame
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must lie in 2..2**CNT_W-1");
    end
    if (REPEAT_RATE_FRAMES < 1 || REPEAT_RATE_FRAMES > REPEAT_DELAY_FRAMES) begin : g_bad_repeat
        $error("REPEAT_RATE_FRAMES must lie in 1..REPEAT_DELAY_FRAMES");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] s1_q, s2_q;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] rel_q, rel_d;
    logic [NUM_KEYS-1:0] latch_q, latch_d;
    logic [NUM_KEYS-1:0] hframe_q, hframe_d;
    logic [NUM_KEYS-1:0] pframe_q, pframe_d;
    logic [NUM_KEYS-1:0] repeat_pf;

    always_comb begin
        held_d  = held_q;
        press_d = '0;
        rel_d   = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (s2_q[k] == held_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DEB_LAST) begin
                cnt_d[k]   = '0;
                held_d[k]  = s2_q[k];
                press_d[k] = s2_q[k];
                rel_d[k]   = ~s2_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // A press pulse coinciding with frame_start goes straight into this frame's snapshot.
    always_comb begin
        latch_d  = latch_q | press_q;
        hframe_d = hframe_q;
        pframe_d = pframe_q;
        if (frame_start) begin
            latch_d  = '0;
            hframe_d = held_q;
            pframe_d = latch_q | press_q | repeat_pf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            held_q   <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            latch_q  <= '0;
            hframe_q <= '0;
            pframe_q <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            s1_q     <= ~keys_n;
            s2_q     <= s1_q;
            held_q   <= held_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            latch_q  <= latch_d;
            hframe_q <= hframe_d;
            pframe_q <= pframe_d;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DELAY_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY_FRAMES - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY_FRAMES - REPEAT_RATE_FRAMES);

    logic [REP_W-1:0]    rep_q [NUM_KEYS];
    logic [REP_W-1:0]    rep_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] pend_q, pend_d;

    // Reaching the delay reloads at once and arms pend, which fires on the following frame_start.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            rep_d[k] = rep_q[k];
            if (!held_q[k]) begin
                rep_d[k]  = '0;
                pend_d[k] = 1'b0;
            end else if (frame_start) begin
                pend_d[k] = 1'b0;
                if (rep_q[k] == REP_LAST) begin
                    rep_d[k]  = REP_RELOAD;
                    pend_d[k] = 1'b1;
                end else begin
                    rep_d[k] = rep_q[k] + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                rep_q[k] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                rep_q[k] <= rep_d[k];
            end
        end
    end

    assign repeat_pf = pend_q;
`else
    assign repeat_pf = '0;
`endif

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign held_frame    = hframe_q;
    assign pressed_frame = pframe_q;

endmodule
